// File: rtl/key_step_debouncer.sv
`default_nettype none
//============================================================================
//  Module      : key_step_debouncer
//  Description : Manual-step pushbutton receiver for the xm23_cpu. Brings the
//                raw active-low KEY input into the CLOCK_50 domain through a
//                two-flop synchroniser, debounces it with a four-state FSM and
//                emits one single-cycle STEP pulse per accepted press.
//
//  Ports       : CLOCK_50   in   system clock, rising edge
//                RESET_N    in   synchronous reset, active low
//                KEY_IN     in   raw pushbutton, asynchronous, 0 = pressed
//                STEP       out  one-cycle pulse per accepted press
//                KEY_LEVEL  out  debounced level, 1 = pressed
//                BUSY       out  1 while a transition is being qualified
//                PRESS_CNT  out  STEP pulses issued, wraps modulo 2^PRESS_W
//
//  Config      : KEY_AUTO_REPEAT_EN - when defined, a held key re-issues STEP
//                every REPEAT_CYCLES cycles. Undefined: one STEP per press.
//
//  Revision    : 1.0 - initial release
//============================================================================
module key_step_debouncer #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 20,
  parameter int PRESS_W         = 16,
  parameter int REPEAT_CYCLES   = 64
) (
  input  logic               CLOCK_50,
  input  logic               RESET_N,
  input  logic               KEY_IN,
  output logic               STEP,
  output logic               KEY_LEVEL,
  output logic               BUSY,
  output logic [PRESS_W-1:0] PRESS_CNT
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT_DN = 2'd1,
    S_HELD    = 2'd2,
    S_WAIT_UP = 2'd3
  } state_t;

  // Terminal count of the qualification window.
  localparam logic [CNT_W-1:0] c_DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic               r_sync1;
  logic               r_sync2;
  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               r_step;
  logic               w_step_nxt;
  logic               r_level;
  logic               w_level_nxt;
  logic [PRESS_W-1:0] r_press_cnt;

`ifdef KEY_AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] c_RPT_LAST = CNT_W'(REPEAT_CYCLES - 1);
  logic [CNT_W-1:0]   r_rpt_cnt;
  logic [CNT_W-1:0]   w_rpt_nxt;
`else
  // REPEAT_CYCLES has no function without auto-repeat; referenced here only
  // so the parameter list stays identical across both builds.
  logic w_unused_cfg;
  assign w_unused_cfg = (REPEAT_CYCLES > 0);
`endif

  // Two-flop synchroniser. Reset value is "released" (high) so a key held
  // through reset still has to be qualified from scratch afterwards.
  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= KEY_IN;
      r_sync2 <= r_sync1;
    end
  end

  // State and datapath registers.
  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_step      <= 1'b0;
      r_level     <= 1'b0;
      r_press_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_step  <= w_step_nxt;
      r_level <= w_level_nxt;
      if (w_step_nxt) begin
        r_press_cnt <= r_press_cnt + PRESS_W'(1);
      end
    end
  end

`ifdef KEY_AUTO_REPEAT_EN
  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      r_rpt_cnt <= '0;
    end else begin
      r_rpt_cnt <= w_rpt_nxt;
    end
  end
`endif

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_step_nxt  = 1'b0;
    w_level_nxt = r_level;
`ifdef KEY_AUTO_REPEAT_EN
    w_rpt_nxt   = r_rpt_cnt;
`endif

    case (r_state)
      S_IDLE: begin
        if (!r_sync2) begin
          w_state_nxt = S_WAIT_DN;
          w_cnt_nxt   = '0;
        end
      end

      S_WAIT_DN: begin
        if (r_sync2) begin
          // Released before the window closed: a glitch, no STEP.
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == c_DB_LAST) begin
          w_state_nxt = S_HELD;
          w_cnt_nxt   = '0;
          w_step_nxt  = 1'b1;
          w_level_nxt = 1'b1;
`ifdef KEY_AUTO_REPEAT_EN
          w_rpt_nxt   = '0;
`endif
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end

      S_HELD: begin
        if (r_sync2) begin
          w_state_nxt = S_WAIT_UP;
          w_cnt_nxt   = '0;
        end else begin
`ifdef KEY_AUTO_REPEAT_EN
          if (r_rpt_cnt == c_RPT_LAST) begin
            w_step_nxt = 1'b1;
            w_rpt_nxt  = '0;
          end else begin
            w_rpt_nxt = r_rpt_cnt + CNT_W'(1);
          end
`endif
        end
      end

      S_WAIT_UP: begin
        if (!r_sync2) begin
          // Release bounce: return to HELD silently.
          w_state_nxt = S_HELD;
          w_cnt_nxt   = '0;
`ifdef KEY_AUTO_REPEAT_EN
          w_rpt_nxt   = '0;
`endif
        end else if (r_cnt == c_DB_LAST) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
          w_level_nxt = 1'b0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign STEP      = r_step;
  assign KEY_LEVEL = r_level;
  assign BUSY      = (r_state == S_WAIT_DN) || (r_state == S_WAIT_UP);
  assign PRESS_CNT = r_press_cnt;

endmodule
`default_nettype wire
